// File: rtl/i2s_tx.sv
// i2s_tx: Philips-format I2S transmitter running on the system clock.
// Derives BCLK/LRCK and shifts one stereo sample per 32-slot frame.
module i2s_tx #(
    parameter int DIV    = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] l,
    input  logic [15:0] r,
    output logic        load,
    output logic        bc,
    output logic        lc,
    output logic        dt
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    logic [7:0]  div_cnt;
    logic [4:0]  slot;
    logic [4:0]  slot_nxt;
    logic [31:0] sr;
    logic [15:0] cl;
    logic [15:0] cr;
    logic        tick;
    logic        fall;

    function automatic logic [15:0] conv(input logic [15:0] x);
        if (SIGNED) return x;
        else        return {~x[15], x[14:0]};
    endfunction

    // Half-period tick, falling-event strobe and converted sample words
    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        fall     = tick & bc;
        slot_nxt = slot + 5'd1;
        cl       = conv(l);
        cr       = conv(r);
    end

    // Prescaler: counts system clocks within each BCLK half-period
    always_ff @(posedge clock or posedge reset) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 8'd1;
    end

    // Bit clock toggles at the end of every half-period
    always_ff @(posedge clock or posedge reset) begin
        if (reset)     bc <= 1'b0;
        else if (tick) bc <= ~bc;
    end

    // Slot counter, word select, shift register and data on BCLK falls;
    // entering slot 1 captures a fresh sample pair and pulses load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot <= '0;
            lc   <= 1'b0;
            dt   <= 1'b0;
            sr   <= '0;
            load <= 1'b0;
        end else begin
            load <= 1'b0;
            if (fall) begin
                slot <= slot_nxt;
                lc   <= slot_nxt[4];
                if (slot_nxt == 5'd1) begin
                    sr   <= {cl, cr};
                    dt   <= cl[15];
                    load <= 1'b1;
                end else begin
                    sr <= {sr[30:0], 1'b0};
                    dt <= sr[30];
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed checks of i2s_tx framing, conversion and reset.
// Three instances: DIV=16 signed, DIV=16 offset-binary, DIV=2 signed.
module tb_i2s_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] l = 16'h0000;
    logic [15:0] r = 16'h0000;
    logic [2:0]  loadv, bcv, lcv, dtv;

    int checks = 0;
    int errors = 0;
    int sel = 0;

    logic load_m, bc_m, lc_m, dt_m;

    i2s_tx #(.DIV(16), .SIGNED(1'b1)) u0 (
        .clock(clock), .reset(reset), .l(l), .r(r),
        .load(loadv[0]), .bc(bcv[0]), .lc(lcv[0]), .dt(dtv[0])
    );
    i2s_tx #(.DIV(16), .SIGNED(1'b0)) u1 (
        .clock(clock), .reset(reset), .l(l), .r(r),
        .load(loadv[1]), .bc(bcv[1]), .lc(lcv[1]), .dt(dtv[1])
    );
    i2s_tx #(.DIV(2), .SIGNED(1'b1)) u2 (
        .clock(clock), .reset(reset), .l(l), .r(r),
        .load(loadv[2]), .bc(bcv[2]), .lc(lcv[2]), .dt(dtv[2])
    );

    always #5 clock = ~clock;

    // Select which instance the capture tasks observe
    always_comb begin
        load_m = loadv[0];
        bc_m   = bcv[0];
        lc_m   = lcv[0];
        dt_m   = dtv[0];
        case (sel)
            1: begin
                load_m = loadv[1]; bc_m = bcv[1];
                lc_m = lcv[1]; dt_m = dtv[1];
            end
            2: begin
                load_m = loadv[2]; bc_m = bcv[2];
                lc_m = lcv[2]; dt_m = dtv[2];
            end
            default: ;
        endcase
    end

    typedef struct {
        int          s;
        logic [15:0] vl;
        logic [15:0] vr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to the next load pulse of the selected instance
    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clock);
            if (load_m) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_load: got timeout expected load");
        end
    endtask

    // Collect 32 dt/lc bits on bc rises starting at slot 1
    task automatic capture(input int chg_idx, input logic [15:0] chg_val,
                           output logic [31:0] word,
                           output logic [31:0] lcs);
        bit ok;
        bit got;
        bit rise;
        logic prev;
        word = '0;
        lcs  = '0;
        wait_load(ok);
        if (!ok) return;
        prev = bc_m;
        for (int i = 0; i < 32; i++) begin
            got = 1'b0;
            for (int n = 0; n < 80 && !got; n++) begin
                @(negedge clock);
                rise = bc_m && !prev;
                prev = bc_m;
                if (rise) got = 1'b1;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL bc_rise: got timeout expected edge");
                return;
            end
            word[31-i] = dt_m;
            lcs[31-i]  = lc_m;
            if (i == chg_idx) l = chg_val;
        end
    endtask

    task automatic measure(input string name, input int exp);
        bit ok;
        int n;
        wait_load(ok);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!load_m && n < 3000);
        chk(name, 32'(n), 32'(exp));
    endtask

    localparam logic [31:0] LC_EXP = 32'h0001_FFFE;

    logic [40:0] bc0, ld0, dt0, bc2, ld2;
    logic [31:0] w, lw;
    bit ok;
    int n;
    bit rise;
    logic prev;

    initial begin
        vecs[0] = '{0, 16'hA5C3, 16'h1234, 32'hA5C3_1234};
        vecs[1] = '{1, 16'h0000, 16'h7FC0, 32'h8000_FFC0};
        vecs[2] = '{1, 16'hFFFF, 16'h0000, 32'h7FFF_8000};
        vecs[3] = '{1, 16'h8000, 16'h8000, 32'h0000_0000};
        vecs[4] = '{2, 16'hA5C3, 16'h1234, 32'hA5C3_1234};

        l = 16'hA5C3;
        r = 16'h1234;
        repeat (3) @(negedge clock);
        chk("reset_outs", {20'd0, bcv, lcv, dtv, loadv}, 32'd0);

        @(posedge clock);
        #1 reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            bc0[k] = bcv[0];
            ld0[k] = loadv[0];
            dt0[k] = dtv[0];
            bc2[k] = bcv[2];
            ld2[k] = loadv[2];
        end
        chk("bc_rise16", {30'd0, bc0[15], bc0[16]}, 32'b01);
        chk("bc_fall32", {30'd0, bc0[31], bc0[32]}, 32'b10);
        chk("load_first", {29'd0, ld0[31], ld0[32], ld0[33]}, 32'b010);
        chk("dt_first", {30'd0, dt0[31], dt0[32]}, 32'b01);
        chk("div2_bc", {28'd0, bc2[1], bc2[2], bc2[3], bc2[4]},
            32'b0110);
        chk("div2_load", {29'd0, ld2[3], ld2[4], ld2[5]}, 32'b010);

        sel = 0;
        measure("load_period16", 1024);
        sel = 2;
        measure("load_period2", 128);
        sel = 0;
        measure("bc_period_frame", 64 * 16);

        for (int v = 0; v < 5; v++) begin
            sel = vecs[v].s;
            l   = vecs[v].vl;
            r   = vecs[v].vr;
            wait_load(ok);
            capture(-1, 16'h0, w, lw);
            chk($sformatf("data_v%0d", v), w, vecs[v].exp);
            chk($sformatf("lc_v%0d", v), lw, LC_EXP);
        end

        sel = 0;
        l = 16'h1111;
        r = 16'h0000;
        wait_load(ok);
        capture(4, 16'hEEEE, w, lw);
        chk("midframe_cur", w, 32'h1111_0000);
        capture(-1, 16'h0, w, lw);
        chk("midframe_next", w, 32'hEEEE_0000);

        l = 16'hA5C3;
        r = 16'h1234;
        wait_load(ok);
        n = 0;
        while (!lc_m && n < 2000) begin
            @(negedge clock);
            n++;
        end
        prev = bc_m;
        for (int f = 0; f < 4; f++) begin
            rise = 1'b0;
            for (int k = 0; k < 80 && !rise; k++) begin
                @(negedge clock);
                rise = prev && !bc_m;
                prev = bc_m;
            end
        end
        chk("pre_reset_lc", {31'd0, lcv[0]}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("async_reset", {28'd0, bcv[0], lcv[0], dtv[0], loadv[0]},
            32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        n = 0;
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end while (!loadv[0] && n < 200);
        chk("restart_latency", 32'(n), 32'd32);
        chk("restart_lc_dt", {30'd0, lcv[0], dtv[0]}, 32'b01);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serial audio transmitter that takes the mixer's left/right sample words and drives an external I2S DAC in standard Philips format. It sits directly downstream of the audio mixer, replacing the external `audio_top` core on the I2S path. It runs entirely on the single system clock it is given: it derives BCLK and LRCK from that clock, latches one stereo sample per frame and strobes the upstream side when it does.

## Interface
- `DIV`, 16: system-clock cycles per BCLK half-period; legal range 2..255.
- `SIGNED`, 0: 0 = inputs are unsigned offset-binary and MSB is inverted before sending; 1 = inputs are already two's complement and sent unchanged.
- `clock`  in  1  system clock (50 MHz in the target build); all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `l`  in  16  left sample word; mixer drives `{ldacD, 6'b0}`.
- `r`  in  16  right sample word; mixer drives `{rdacD, 6'b0}`.
- `load`  out  1  one-clock strobe in the cycle `l`/`r` are captured.
- `bc`  out  1  I2S bit clock (BCLK).
- `lc`  out  1  I2S word select (LRCK); 0 = left, 1 = right.
- `dt`  out  1  I2S serial data, MSB first.

## Operation
- Prescaler `div_cnt`, 0..DIV-1:
  - Increments every clock.
  - At DIV-1 it wraps to 0 and `bc` toggles.
- Falling event: the clock edge on which `bc` goes 1->0. On this event:
  - `slot` (5 bits) increments modulo 32.
  - `lc` and `dt` are updated for the new slot.
- Frame layout, 32 slots:
  - `lc` = 0 for slots 0..15 and 1 for slots 16..31, i.e. `lc` = new `slot[4]`.
  - Slots 1..16 carry L[15]..L[0]; slots 17..31 carry R[15]..R[1].
  - Slot 0 of the following frame carries R[0]. This gives the Philips one-BCLK data delay relative to `lc`.
- On the falling event that enters slot 1:
  - The 32-bit shift register `sr` loads `{conv(l), conv(r)}`.
  - `dt` takes `conv(l)[15]` on the same edge.
  - `load` = 1 for that single clock.
- On every other falling event, `sr` shifts left by one and `dt` takes the new `sr[31]`.
- Conversion: `conv(x)` = `{~x[15], x[14:0]}` when SIGNED=0, and `x` when SIGNED=1.
- `l`/`r` are ignored outside the load cycle. Changes mid-frame take effect in the next frame.
- No handshake back-pressure: upstream holds values steady. `load` is informational (sample-rate tick).

## Timing
- Reset values: `div_cnt`=0, `bc`=0, `slot`=0, `lc`=0, `dt`=0, `sr`=0, `load`=0. All are asserted asynchronously, with no clock edge needed.
- After reset deassertion:
  - First `bc` rise on the DIV-th rising clock edge.
  - First fall on the 2·DIV-th edge.
  - That fall is the first load: `load`=1 in the cycle following that edge; `dt` = converted left MSB.
- Periods:
  - BCLK period = 2·DIV clocks.
  - Frame, `lc` and `load` period = 64·DIV clocks. Defaults give 1024 clocks, i.e. 48.828 kHz at 50 MHz.
- Transition edges:
  - `lc`, `dt` and `load` change only on the falling-event edge, so the receiver samples `dt` on `bc` rising with DIV clocks of setup.
  - `lc` falls on entering slot 0 and rises on entering slot 16. `lc` never changes on a `bc` rising edge.
- Frames are back-to-back with no idle slots. The sequence is deterministic after reset.
- Reset mid-frame aborts the frame: outputs go to reset values immediately and the restart follows the rule above. The partial frame is not resumed.
- All outputs are registered; no combinational path from `l`/`r` to any output.

## Test plan
- Reset/startup (DIV=16):
  - While reset is held, `bc`/`lc`/`dt`/`load` = 0.
  - After release: `bc` rises at edge 16, falls at edge 32, `load` high for exactly one clock there.
  - Next `load` is 1024 clocks later.
- Serial data (SIGNED=1), l=16'hA5C3, r=16'h1234 held:
  - Sample `dt` on 32 `bc` rises starting at slot 1; expect A5C3 then 1234, with R[0]=0 in slot 0.
  - `lc`=0 for the first 15 bits plus the next-frame slot 0 bit, and 1 for slots 16..31.
- Offset conversion (SIGNED=0):
  - l=16'h0000 -> sent 16'h8000.
  - l=16'hFFFF -> 16'h7FFF.
  - l=16'h8000 -> 16'h0000.
  - r=16'h7FC0 -> 16'hFFC0.
- Mid-frame change: switch l from 16'h1111 to 16'hEEEE during slot 5. The current frame still sends 1111; the next frame sends EEEE.
- Async reset in slot 20:
  - Outputs drop to 0 in the same cycle, without waiting for a clock edge.
  - After release, the first `load` comes 2·DIV clocks later with `lc`=0.
- DIV=2:
  - BCLK period is 4 clocks; `load` period is 128 clocks.
  - Bit sequence is identical to the data scenario.
